// File: rtl/periph_fifo_tracked.sv
// periph_fifo_tracked: request buffer between a periph master port and the peripheral
// interconnect. Queues requests in a DEPTH-entry FIFO (optional fall-through), caps the
// number of requests granted downstream but not yet answered, and forwards responses
// either combinationally or through one register stage.
module periph_fifo_tracked #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BYTE_ENABLE_BIT = DATA_WIDTH / 8,
  parameter int unsigned DEPTH           = 4,
  parameter bit          FALL_THROUGH    = 1'b0,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          RESP_REG        = 1'b0,
  localparam int unsigned FILL_W         = $clog2(DEPTH + 1),
  localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       test_en_i,
  input  logic                       data_req_i,
  input  logic [ADDR_WIDTH-1:0]      data_add_i,
  input  logic                       data_wen_i,
  input  logic [5:0]                 data_atop_i,
  input  logic [DATA_WIDTH-1:0]      data_wdata_i,
  input  logic [BYTE_ENABLE_BIT-1:0] data_be_i,
  output logic                       data_gnt_o,
  output logic                       data_req_o,
  output logic [ADDR_WIDTH-1:0]      data_add_o,
  output logic                       data_wen_o,
  output logic [5:0]                 data_atop_o,
  output logic [DATA_WIDTH-1:0]      data_wdata_o,
  output logic [BYTE_ENABLE_BIT-1:0] data_be_o,
  input  logic                       data_gnt_i,
  input  logic                       data_r_valid_i,
  input  logic                       data_r_opc_i,
  input  logic [DATA_WIDTH-1:0]      data_r_rdata_i,
  output logic                       data_r_valid_o,
  output logic                       data_r_opc_o,
  output logic [DATA_WIDTH-1:0]      data_r_rdata_o,
  output logic [FILL_W-1:0]          fill_o,
  output logic [OUT_W-1:0]           outstanding_o,
  output logic                       idle_o,
  output logic                       resp_err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      add;
    logic                       wen;
    logic [5:0]                 atop;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [BYTE_ENABLE_BIT-1:0] be;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head_entry;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [FILL_W-1:0] fill_q;
  logic [OUT_W-1:0] outst_q;
  logic             resp_err_q;
  logic             empty;
  logic             full;
  logic             can_issue;
  logic             bypass;
  logic             push;
  logic             store;
  logic             issue;
  logic             fifo_pop;
  logic             resp_spurious;
  logic             resp_dec;

  // Clock-gate test enable has no functional effect inside this block.
  logic unused_test_en;
  assign unused_test_en = test_en_i;

  // Pointers run 0..DEPTH-1 and wrap, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign in_entry = '{add: data_add_i, wen: data_wen_i, atop: data_atop_i,
                      wdata: data_wdata_i, be: data_be_i};

  // Grant comes only from the registered fill level, never from data_gnt_i.
  assign empty      = (fill_q == '0);
  assign full       = (fill_q == FILL_W'(DEPTH));
  assign can_issue  = (outst_q < OUT_W'(MAX_OUTSTANDING));
  assign data_gnt_o = !full;
  assign push       = data_req_i && !full;

  // In fall-through mode an empty FIFO presents the incoming request directly.
  assign bypass     = FALL_THROUGH && empty;
  assign head_entry = bypass ? in_entry : mem[rd_ptr_q];
  assign data_req_o = can_issue && (bypass ? data_req_i : !empty);
  assign issue      = data_req_o && data_gnt_i;
  assign fifo_pop   = issue && !empty;
  assign store      = push && !(bypass && issue);

  assign data_add_o   = head_entry.add;
  assign data_wen_o   = head_entry.wen;
  assign data_atop_o  = head_entry.atop;
  assign data_wdata_o = head_entry.wdata;
  assign data_be_o    = head_entry.be;

  // A response with nothing in flight is flagged and must not decrement the counter.
  assign resp_spurious = data_r_valid_i && (outst_q == '0);
  assign resp_dec      = data_r_valid_i && !resp_spurious;

  // Storage array; contents are don't-care while the FIFO is empty, so it has no reset.
  always_ff @(posedge clk_i) begin
    if (store) mem[wr_ptr_q] <= in_entry;
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (store)    wr_ptr_q <= next_ptr(wr_ptr_q);
      if (fifo_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({store, fifo_pop})
        2'b10:   fill_q <= fill_q + FILL_W'(1);
        2'b01:   fill_q <= fill_q - FILL_W'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Outstanding-request counter and spurious-response pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      resp_err_q <= resp_spurious;
      case ({issue, resp_dec})
        2'b10:   outst_q <= outst_q + OUT_W'(1);
        2'b01:   outst_q <= outst_q - OUT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  assign fill_o        = fill_q;
  assign outstanding_o = outst_q;
  assign idle_o        = empty && (outst_q == '0);
  assign resp_err_o    = resp_err_q;

  generate
    if (RESP_REG) begin : g_resp_reg
      logic                  r_valid_q;
      logic                  r_opc_q;
      logic [DATA_WIDTH-1:0] r_rdata_q;

      // Registered response copy; payload holds its last value between responses.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_valid_q <= 1'b0;
          r_opc_q   <= 1'b0;
          r_rdata_q <= '0;
        end else begin
          r_valid_q <= data_r_valid_i;
          if (data_r_valid_i) begin
            r_opc_q   <= data_r_opc_i;
            r_rdata_q <= data_r_rdata_i;
          end
        end
      end

      assign data_r_valid_o = r_valid_q;
      assign data_r_opc_o   = r_opc_q;
      assign data_r_rdata_o = r_rdata_q;
    end else begin : g_resp_pass
      assign data_r_valid_o = data_r_valid_i;
      assign data_r_opc_o   = data_r_opc_i;
      assign data_r_rdata_o = data_r_rdata_i;
    end
  endgenerate

endmodule
